// File: rtl/fpu_operand_sequencer.sv
// Operand-pair FIFO feeding an FPU with no handshake: each pair is held on the
// FPU inputs for HOLD_CYCLES cycles, then the result/status is captured and strobed.
module fpu_operand_sequencer #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_op_a,
    input  logic [31:0]                in_op_b,
    output logic [31:0]                op_a_out,
    output logic [31:0]                op_b_out,
    input  logic [31:0]                fpu_data_in,
    input  logic [3:0]                 fpu_status_in,
    output logic                       res_valid,
    output logic [31:0]                res_data,
    output logic [3:0]                 res_status,
    output logic [3:0]                 status_sticky,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [31:0]       res_data_q, res_data_d;
    logic [3:0]        res_status_q, res_status_d;
    logic [3:0]        sticky_q, sticky_d;
    logic              res_valid_q, res_valid_d;

    logic [63:0]       mem_q [DEPTH];
    logic              push;
    logic              pop;

    // Ready looks only at the registered count, so a full FIFO never accepts
    // on the strength of a same-cycle pop.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        hold_cnt_d   = hold_cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        sticky_d     = sticky_q;
        res_valid_d  = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    {op_a_d, op_b_d} = mem_q[rd_ptr_q];
                    hold_cnt_d       = HOLD_W'(HOLD_CYCLES - 1);
                    state_d          = APPLY;
                end
            end
            APPLY: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end else begin
                    res_data_d   = fpu_data_in;
                    res_status_d = fpu_status_in;
                    sticky_d     = sticky_q | fpu_status_in;
                    res_valid_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: storage array is not reset; the pointers and count decide what is
    // valid, so clearing the entries would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_op_a, in_op_b};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_cnt_q   <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_data_q   <= '0;
            res_status_q <= '0;
            sticky_q     <= '0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_cnt_q   <= hold_cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            sticky_q     <= sticky_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign op_a_out      = op_a_q;
    assign op_b_out      = op_b_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;
    assign res_status    = res_status_q;
    assign status_sticky = sticky_q;
    assign busy          = (state_q == APPLY);
    assign count         = count_q;

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Directed bench for fpu_operand_sequencer with a two-stage FPU stand-in
// (data = op_a + op_b, status = op_b[23:20]).
module tb_fpu_operand_sequencer;

    localparam int DEPTH = 8;
    localparam int HOLD  = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic [31:0] op_a_out;
    logic [31:0] op_b_out;
    logic [31:0] fpu_data_in;
    logic [3:0]  fpu_status_in;
    logic        res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_status;
    logic [3:0]  status_sticky;
    logic        busy;
    logic [3:0]  count;

    fpu_operand_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op_a       (in_op_a),
        .in_op_b       (in_op_b),
        .op_a_out      (op_a_out),
        .op_b_out      (op_b_out),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_status    (res_status),
        .status_sticky (status_sticky),
        .busy          (busy),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPU stand-in with two cycles of latency (less than the hold window)
    logic [31:0] fpu_s1_data;
    logic [3:0]  fpu_s1_st;
    always @(posedge clk) begin
        fpu_s1_data   <= op_a_out + op_b_out;
        fpu_s1_st     <= op_b_out[23:20];
        fpu_data_in   <= fpu_s1_data;
        fpu_status_in <= fpu_s1_st;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // Result monitor plus hold-window watchers
    logic [35:0] res_q[$];
    int          res_cyc[$];
    logic        busy_prev = 1'b0;
    logic [31:0] held_a, held_b;
    int          run_len = 0;
    int          stab_err = 0;
    int          run_err = 0;
    always @(negedge clk) begin
        if (res_valid) begin
            res_q.push_back({res_data, res_status});
            res_cyc.push_back(cyc);
        end
        if (!rst) begin
            busy_prev = 1'b0;
            run_len   = 0;
        end else begin
            if (busy) begin
                if (!busy_prev) begin
                    held_a  = op_a_out;
                    held_b  = op_b_out;
                    run_len = 1;
                end else begin
                    run_len++;
                    if (op_a_out !== held_a || op_b_out !== held_b) stab_err++;
                end
            end else if (busy_prev && run_len != HOLD) begin
                run_err++;
            end
            busy_prev = busy;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_results(input string name, input int n);
        int budget = 300;
        while (res_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        repeat (12) tick();
        check(name, 64'(res_q.size()), 64'(n));
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic [3:0]  exp_status;
        logic [3:0]  exp_count;
    } vec_t;

    vec_t        vecs[6];
    logic [35:0] exp_q[$];
    logic [35:0] got;
    int          n_push;

    initial begin
        vecs[0] = '{32'h00700000, 32'h00500000, 32'h00C00000, 4'h5, 4'd1};
        vecs[1] = '{32'h00600000, 32'h00000000, 32'h00600000, 4'h0, 4'd1};
        vecs[2] = '{32'h00600000, 32'h00600000, 32'h00C00000, 4'h6, 4'd2};
        vecs[3] = '{32'h12345678, 32'h0F0F0F0F, 32'h21436587, 4'h0, 4'd3};
        vecs[4] = '{32'hFFFFFFFF, 32'h00A00001, 32'h00A00000, 4'hA, 4'd4};
        vecs[5] = '{32'h80000000, 32'h80300000, 32'h00300000, 4'h3, 4'd5};

        rst = 1'b0; in_valid = 1'b0; in_op_a = '0; in_op_b = '0;

        // Reset state
        tick(); tick();
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_count", 64'(count), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_res_valid", 64'(res_valid), 0);
        check("rst_ops", {op_a_out, op_b_out}, 0);
        check("rst_res", {28'h0, res_data, res_status}, 0);
        check("rst_sticky", 64'(status_sticky), 0);
        rst = 1'b1;
        tick();

        // Single operation: exact pop / hold / capture timing
        res_q.delete(); res_cyc.delete();
        in_valid = 1'b1; in_op_a = 32'h00500000; in_op_b = 32'h00600000;
        tick();
        in_valid = 1'b0;
        check("single_push_count", 64'(count), 1);
        check("single_push_busy", 64'(busy), 0);
        tick();
        check("single_pop_busy", 64'(busy), 1);
        check("single_pop_ops", {op_a_out, op_b_out}, {32'h00500000, 32'h00600000});
        check("single_pop_count", 64'(count), 0);
        for (int k = 1; k < HOLD; k++) begin
            tick();
            check($sformatf("single_hold%0d", k), {30'h0, busy, res_valid, op_a_out}, {30'h0, 1'b1, 1'b0, 32'h00500000});
        end
        tick();
        check("single_capture_valid", 64'(res_valid), 1);
        check("single_capture_busy", 64'(busy), 0);
        check("single_capture_res", {28'h0, res_data, res_status}, {28'h0, 32'h00B00000, 4'h6});
        tick();
        check("single_strobe_drop", 64'(res_valid), 0);
        check("single_res_hold", 64'(res_data), 64'h00B00000);
        check("single_ops_kept", 64'(op_a_out), 64'h00500000);
        wait_results("single_result_count", 1);

        // Table: back-to-back pushes, in-order results, fixed spacing
        res_q.delete(); res_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_op_a = vecs[i].a; in_op_b = vecs[i].b;
            tick();
            check($sformatf("tbl_count%0d", i), 64'(count), 64'(vecs[i].exp_count));
        end
        in_valid = 1'b0;
        tick();
        check("tbl_count_pop", 64'(count), 4);
        wait_results("tbl_result_count", 6);
        for (int i = 0; i < 6; i++) begin
            got = (i < res_q.size()) ? res_q[i] : 36'h0;
            check($sformatf("tbl_res%0d", i), 64'(got), 64'({vecs[i].exp_data, vecs[i].exp_status}));
            if (i > 0 && i < res_cyc.size())
                check($sformatf("tbl_gap%0d", i), 64'(res_cyc[i] - res_cyc[i-1]), HOLD + 1);
        end

        // Full FIFO: fill while operations run, then offer one extra
        res_q.delete(); res_cyc.delete(); exp_q.delete();
        n_push = 0;
        while (n_push < 16 && in_ready) begin
            in_valid = 1'b1;
            in_op_a  = 32'h01000000 * (n_push + 1);
            in_op_b  = 32'(n_push + 1) << 20;
            exp_q.push_back({in_op_a + in_op_b, in_op_b[23:20]});
            n_push++;
            tick();
        end
        check("full_accepted", 64'(n_push), 10);
        check("full_count", 64'(count), DEPTH);
        in_op_a = 32'hDEAD0000; in_op_b = 32'h00000000;
        tick();
        in_valid = 1'b0;
        check("full_extra_count", 64'(count), DEPTH);
        check("full_extra_ready", 64'(in_ready), 0);
        tick();
        check("full_ready_back", 64'(in_ready), 1);
        wait_results("full_result_count", 10);
        for (int i = 0; i < 10; i++) begin
            got = (i < res_q.size()) ? res_q[i] : 36'h0;
            check($sformatf("full_res%0d", i), 64'(got), 64'(exp_q[i]));
        end

        // Reset during APPLY with two pairs still queued
        res_q.delete(); res_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_op_a = 32'hAAA00000 + i; in_op_b = 32'h00700000;
            tick();
        end
        in_valid = 1'b0;
        check("midrst_pre_busy", 64'(busy), 1);
        check("midrst_pre_count", 64'(count), 2);
        rst = 1'b0;
        tick();
        check("midrst_count", 64'(count), 0);
        check("midrst_busy", 64'(busy), 0);
        check("midrst_outs", {op_a_out, 28'h0, status_sticky}, 0);
        rst = 1'b1;
        repeat (30) tick();
        check("midrst_no_result", 64'(res_q.size()), 0);

        // Sticky status accumulates while res_status tracks the last capture
        res_q.delete(); res_cyc.delete();
        in_valid = 1'b1; in_op_a = 32'h00000001; in_op_b = 32'h00400000;
        tick();
        in_op_a = 32'h00000002; in_op_b = 32'h00100000;
        tick();
        in_valid = 1'b0;
        wait_results("sticky_result_count", 2);
        check("sticky_first_status", 64'((res_q.size() > 0) ? res_q[0][3:0] : 4'hF), 4);
        check("sticky_value", 64'(status_sticky), 64'h5);
        check("sticky_res_status", 64'(res_status), 64'h1);
        check("sticky_res_data", 64'(res_data), 64'h00100002);

        check("hold_stable", 64'(stab_err), 0);
        check("busy_run_len", 64'(run_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
